lfsr_noise_src: RTL and testbench

Galois-LFSR white-noise sample source that sits directly upstream of the 2nd-order IIR section. It generates the shaped-noise chain's excitation samples.
- Produces one signed W-bit sample per programmable sample period.
- Drives the IIR input bus from `sample`.
- Drives the IIR `en` input from the one-cycle `sample_en` strobe.
- Advances the LFSR NSH times per sample, serially, so that adjacent samples are decorrelated.

---
 rtl/lfsr_noise_src_pkg.sv | 29 ++
 rtl/lfsr_galois_step.sv | 12 +
 rtl/lfsr_noise_src.sv | 105 ++++++++++
 tb/tb_lfsr_noise_src.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/lfsr_noise_src_pkg.sv
// Shared constants and types for the Galois-LFSR noise source and related LFSR blocks.
// Tap masks are right-shift Galois masks giving maximal-length sequences.
package lfsr_noise_src_pkg;

  localparam logic [15:0] TAPS_W16 = 16'hB400;
  localparam logic [23:0] TAPS_W24 = 24'hE10000;
  localparam logic [31:0] TAPS_W32 = 32'h80200003;

  localparam logic [15:0] SEED_W16 = 16'h0001;
  localparam logic [23:0] SEED_W24 = 24'h000001;
  localparam logic [31:0] SEED_W32 = 32'h00000001;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } lfsr_state_t;

  // Unsupported widths fall back to the 32-bit mask; callers must override TAPS.
  function automatic logic [31:0] default_taps(input int w);
    logic [31:0] t;
    case (w)
      16:      t = {16'h0000, TAPS_W16};
      24:      t = {8'h00, TAPS_W24};
      default: t = TAPS_W32;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/lfsr_galois_step.sv
// One combinational right-shift Galois LFSR step: nxt = (cur >> 1) ^ (cur[0] ? TAPS : 0).
module lfsr_galois_step #(
  parameter int           W    = 32,
  parameter logic [W-1:0] TAPS = 32'h80200003
) (
  input  logic [W-1:0] cur,
  output logic [W-1:0] nxt
);

  assign nxt = (cur >> 1) ^ (cur[0] ? TAPS : '0);

endmodule

// File: rtl/lfsr_noise_src.sv
// White-noise excitation source: a Galois LFSR advanced NSH times per programmable
// sample period, emitting an attenuated signed sample with a one-cycle strobe.
module lfsr_noise_src
  import lfsr_noise_src_pkg::*;
#(
  parameter int           W        = 32,
  parameter logic [W-1:0] TAPS     = W'(default_taps(W)),
  parameter logic [W-1:0] SEED_DEF = W'(SEED_W32),
  parameter int           NSH      = 8,
  parameter int           DW       = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                run,
  input  logic [DW-1:0]       div,
  input  logic [4:0]          att,
  input  logic                seed_load,
  input  logic [W-1:0]        seed,
  output logic signed [W-1:0] sample,
  output logic                sample_en,
  output logic                overrun,
  output logic                lockup
);

  localparam int SHW = (NSH > 1) ? $clog2(NSH) : 1;

  logic [DW-1:0]  cnt;
  logic [SHW-1:0] sh_cnt;
  lfsr_state_t    state;
  logic [W-1:0]   lfsr;
  logic [W-1:0]   lfsr_nxt;
  logic           tick;
  logic           last_shift;

  lfsr_galois_step #(
    .W    (W),
    .TAPS (TAPS)
  ) u_step (
    .cur (lfsr),
    .nxt (lfsr_nxt)
  );

  assign tick       = run && (cnt == div);
  assign last_shift = (state == SHIFT) && (sh_cnt == SHW'(NSH - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (seed_load) begin
      cnt <= '0;
    end else if (run) begin
      cnt <= tick ? '0 : cnt + 1'b1;
    end
  end

  // seed_load outranks the tick and aborts a sample in flight without a strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr      <= SEED_DEF;
      state     <= IDLE;
      sh_cnt    <= '0;
      sample    <= '0;
      sample_en <= 1'b0;
      overrun   <= 1'b0;
      lockup    <= 1'b0;
    end else begin
      sample_en <= 1'b0;
      lockup    <= 1'b0;
      if (seed_load) begin
        lfsr    <= seed;
        state   <= IDLE;
        sh_cnt  <= '0;
        overrun <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (tick) begin
              if (lfsr == '0) begin
                lfsr   <= SEED_DEF;
                lockup <= 1'b1;
              end
              state  <= SHIFT;
              sh_cnt <= '0;
            end
          end
          SHIFT: begin
            if (tick) begin
              overrun <= 1'b1;
            end
            lfsr   <= lfsr_nxt;
            sh_cnt <= sh_cnt + 1'b1;
            if (last_shift) begin
              sample    <= $signed(lfsr_nxt) >>> att;
              sample_en <= 1'b1;
              state     <= IDLE;
              sh_cnt    <= '0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lfsr_noise_src.sv
// Bench for lfsr_noise_src: three instances (NSH=8,1,2) share stimulus and are checked
// against an event-scheduled reference model plus table-driven and hand-written sequences.
module tb_lfsr_noise_src;

  localparam int          W    = 32;
  localparam int          DW   = 16;
  localparam logic [W-1:0] TAPS = 32'h80200003;
  localparam logic [W-1:0] SEED = 32'h00000001;
  localparam int          NSHS [3] = '{8, 1, 2};

  logic          clk = 1'b0;
  logic          rst, run, seed_load;
  logic [DW-1:0] div;
  logic [4:0]    att;
  logic [W-1:0]  seed;

  logic signed [W-1:0] smp [3];
  logic                en  [3];
  logic                ovr [3];
  logic                lck [3];

  int checks = 0;
  int errors = 0;

  lfsr_noise_src #(.W(W), .TAPS(TAPS), .SEED_DEF(SEED), .NSH(8), .DW(DW)) u_dut8 (
    .clk(clk), .rst(rst), .run(run), .div(div), .att(att), .seed_load(seed_load),
    .seed(seed), .sample(smp[0]), .sample_en(en[0]), .overrun(ovr[0]), .lockup(lck[0]));

  lfsr_noise_src #(.W(W), .TAPS(TAPS), .SEED_DEF(SEED), .NSH(1), .DW(DW)) u_dut1 (
    .clk(clk), .rst(rst), .run(run), .div(div), .att(att), .seed_load(seed_load),
    .seed(seed), .sample(smp[1]), .sample_en(en[1]), .overrun(ovr[1]), .lockup(lck[1]));

  lfsr_noise_src #(.W(W), .TAPS(TAPS), .SEED_DEF(SEED), .NSH(2), .DW(DW)) u_dut2 (
    .clk(clk), .rst(rst), .run(run), .div(div), .att(att), .seed_load(seed_load),
    .seed(seed), .sample(smp[2]), .sample_en(en[2]), .overrun(ovr[2]), .lockup(lck[2]));

  always #5 clk = ~clk;

  // Reference model: a tick accepted at cycle c yields the fully advanced value at
  // once and schedules its strobe; ticks up to c+NSH are dropped as overruns.
  longint              mcyc = 0;
  logic [DW-1:0]       m_cnt;
  logic [W-1:0]        m_lfsr [3];
  bit                  pend   [3];
  logic [W-1:0]        pend_v [3];
  longint              busy   [3];
  logic signed [W-1:0] e_smp  [3];
  bit                  e_en   [3];
  bit                  e_ovr  [3];
  bit                  e_lck  [3];

  function automatic logic [W-1:0] galois(input logic [W-1:0] v, input int n);
    logic [W-1:0] x;
    x = v;
    for (int i = 0; i < n; i++) x = x[0] ? ((x >> 1) ^ TAPS) : (x >> 1);
    return x;
  endfunction

  task automatic modelStep();
    bit tk;
    tk = run && (m_cnt == div);
    for (int k = 0; k < 3; k++) begin
      e_en[k]  = 1'b0;
      e_lck[k] = 1'b0;
      if (rst) begin
        m_lfsr[k] = SEED; pend[k] = 1'b0; busy[k] = -1;
        e_smp[k] = '0; e_ovr[k] = 1'b0;
      end else if (seed_load) begin
        m_lfsr[k] = seed; pend[k] = 1'b0; busy[k] = -1; e_ovr[k] = 1'b0;
      end else begin
        if (pend[k] && mcyc == busy[k]) begin
          e_smp[k] = $signed(pend_v[k]) >>> att;
          e_en[k]  = 1'b1;
          pend[k]  = 1'b0;
        end
        if (tk) begin
          if (mcyc <= busy[k]) e_ovr[k] = 1'b1;
          else begin
            if (m_lfsr[k] == '0) begin
              m_lfsr[k] = SEED;
              e_lck[k]  = 1'b1;
            end
            m_lfsr[k] = galois(m_lfsr[k], NSHS[k]);
            pend_v[k] = m_lfsr[k];
            pend[k]   = 1'b1;
            busy[k]   = mcyc + NSHS[k];
          end
        end
      end
    end
    if (rst || seed_load) m_cnt = '0;
    else if (run) m_cnt = tk ? '0 : m_cnt + 1'b1;
    mcyc++;
  endtask

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic checkOutput();
    for (int k = 0; k < 3; k++) begin
      check($sformatf("model sample nsh%0d", NSHS[k]), smp[k], e_smp[k]);
      check($sformatf("model sample_en nsh%0d", NSHS[k]), W'(en[k]), W'(e_en[k]));
      check($sformatf("model overrun nsh%0d", NSHS[k]), W'(ovr[k]), W'(e_ovr[k]));
      check($sformatf("model lockup nsh%0d", NSHS[k]), W'(lck[k]), W'(e_lck[k]));
    end
  endtask

  task automatic applyStimulus(input logic r, input logic rn, input logic [DW-1:0] d,
                               input logic [4:0] a, input logic sl, input logic [W-1:0] s);
    rst = r; run = rn; div = d; att = a; seed_load = sl; seed = s;
    @(posedge clk);
    modelStep();
    #1;
    checkOutput();
  endtask

  typedef struct {
    logic [W-1:0] seed;
    logic [4:0]   att;
    logic [W-1:0] exp1;
    logic [W-1:0] exp2;
    bit           exp_lock;
  } vec_t;

  vec_t vecs [7];

  initial begin
    int first_en, second_en, en_cnt;
    bit prev_en, dbl_en, seen_lock, seen1, seen2;
    logic [W-1:0] got1, got2;
    logic [DW-1:0] d;
    logic [4:0] a;
    logic [W-1:0] s;
    logic sl, rn, r;

    vecs[0] = '{32'h00000001, 5'd0,  32'h80200003, 32'hC0300002, 1'b0};
    vecs[1] = '{32'h00000001, 5'd4,  32'hF8020000, 32'hFC030000, 1'b0};
    vecs[2] = '{32'h00000001, 5'd31, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0};
    vecs[3] = '{32'h00000002, 5'd0,  32'h00000001, 32'h80200003, 1'b0};
    vecs[4] = '{32'h00000000, 5'd0,  32'h80200003, 32'hC0300002, 1'b1};
    vecs[5] = '{32'h00000004, 5'd31, 32'h00000000, 32'h00000000, 1'b0};
    vecs[6] = '{32'h80000000, 5'd1,  32'h20000000, 32'h10000000, 1'b0};

    // Reset with conflicting inputs active, then the nominal div=15 cadence.
    applyStimulus(1'b1, 1'b1, 16'd15, 5'd0, 1'b1, 32'hDEADBEEF);
    for (int k = 0; k < 3; k++) begin
      check("reset sample", smp[k], '0);
      check("reset flags", {29'd0, en[k], ovr[k], lck[k]}, '0);
    end
    first_en = -1; second_en = -1; prev_en = 1'b0; dbl_en = 1'b0;
    for (int i = 0; i < 45; i++) begin
      applyStimulus(1'b0, 1'b1, 16'd15, 5'd0, 1'b0, '0);
      if (en[0]) begin
        if (first_en < 0) first_en = i + 1;
        else if (second_en < 0) second_en = i + 1;
      end
      if (en[0] && prev_en) dbl_en = 1'b1;
      prev_en = en[0];
    end
    check("first sample_en cycle", W'(first_en), W'(24));
    check("second sample_en cycle", W'(second_en), W'(40));
    check("sample_en back-to-back", W'(dbl_en), '0);

    // Single-sample vectors: load seed, one tick, collect NSH=1 and NSH=2 results.
    foreach (vecs[v]) begin
      applyStimulus(1'b0, 1'b0, 16'd0, vecs[v].att, 1'b1, vecs[v].seed);
      applyStimulus(1'b0, 1'b1, 16'd0, vecs[v].att, 1'b0, '0);
      seen_lock = lck[1]; seen1 = 1'b0; seen2 = 1'b0; got1 = 'x; got2 = 'x;
      for (int i = 0; i < 5; i++) begin
        applyStimulus(1'b0, 1'b0, 16'd0, vecs[v].att, 1'b0, '0);
        if (lck[1]) seen_lock = 1'b1;
        if (en[1] && !seen1) begin seen1 = 1'b1; got1 = smp[1]; end
        if (en[2] && !seen2) begin seen2 = 1'b1; got2 = smp[2]; end
      end
      check($sformatf("vec%0d sample nsh1", v), got1, vecs[v].exp1);
      check($sformatf("vec%0d sample nsh2", v), got2, vecs[v].exp2);
      check($sformatf("vec%0d lockup", v), W'(seen_lock), W'(vecs[v].exp_lock));
    end

    // Overrun: div=3 with NSH=8 drops the second tick; seed_load clears it.
    applyStimulus(1'b0, 1'b0, 16'd3, 5'd0, 1'b1, 32'h00000001);
    for (int i = 0; i < 30; i++) begin
      applyStimulus(1'b0, 1'b1, 16'd3, 5'd0, 1'b0, '0);
      if (i == 6) check("overrun before 2nd tick", W'(ovr[0]), '0);
      if (i == 7) check("overrun after 2nd tick", W'(ovr[0]), W'(1));
    end
    applyStimulus(1'b0, 1'b0, 16'd3, 5'd0, 1'b1, 32'h00000001);
    check("overrun cleared by seed_load", W'(ovr[0]), '0);

    // Reset in the middle of a shift sequence: the aborted sample never strobes.
    applyStimulus(1'b0, 1'b1, 16'd0, 5'd0, 1'b0, '0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 16'd0, 5'd0, 1'b0, '0);
    applyStimulus(1'b1, 1'b0, 16'd0, 5'd0, 1'b0, '0);
    check("mid-shift reset sample", smp[0], '0);
    check("mid-shift reset flags", {29'd0, en[0], ovr[0], lck[0]}, '0);
    en_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      applyStimulus(1'b0, 1'b0, 16'd0, 5'd0, 1'b0, '0);
      en_cnt += int'(en[0]) + int'(en[1]) + int'(en[2]);
    end
    check("strobes after mid-shift reset", W'(en_cnt), '0);

    // seed_load coincident with a tick: the tick is lost.
    applyStimulus(1'b0, 1'b1, 16'd0, 5'd0, 1'b1, 32'h00000005);
    en_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      applyStimulus(1'b0, 1'b0, 16'd0, 5'd0, 1'b0, '0);
      en_cnt += int'(en[0]) + int'(en[1]) + int'(en[2]) + int'(lck[0]);
    end
    check("strobes after seed_load+tick", W'(en_cnt), '0);

    // Randomized traffic against the model.
    d = 16'd5; a = 5'd0; s = 32'h1;
    for (int i = 0; i < 3000; i++) begin
      r  = ($urandom_range(0, 299) == 0);
      sl = (i == 0) || ($urandom_range(0, 39) == 0);
      if (sl) begin
        s = ($urandom_range(0, 3) == 0) ? '0 : W'($urandom);
        d = DW'($urandom_range(0, 20));
      end
      if ($urandom_range(0, 63) == 0) a = 5'($urandom_range(0, 31));
      rn = ($urandom_range(0, 7) != 0);
      applyStimulus(r, rn, d, a, sl, s);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
